serial_adder_n: RTL and testbench
=================================

// Module: serial_adder_n
// PURPOSE
//  Parametrised bit-serial adder/subtractor: one full-adder cell plus a carry flop
//  processes WIDTH-bit operands LSB first, one bit per clock, under a start/done handshake.
//  Next generation of the half/full adder cells: arbitrary width, add/sub mode,
//  carry and signed-overflow flags. Used where area matters more than latency.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..64
// PORTS
//  clk    in   1      rising-edge clock
//  rst    in   1      asynchronous, active-high reset
//  start  in   1      request; sampled on clk edge, accepted only when busy==0
//  sub    in   1      0: a+b, 1: a-b; sampled with start
//  a      in   WIDTH  operand A; sampled with start
//  b      in   WIDTH  operand B; sampled with start
//  busy   out  1      high while bits are being processed
//  done   out  1      single-cycle pulse: result registers just updated
//  sum    out  WIDTH  result; held stable from done until the next completion
//  cout   out  1      carry out of MSB (sub: 1 = no borrow, i.e. a >= b unsigned)
//  ovf    out  1      two's-complement overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  Only clock: clk. Reset: rst, asynchronous, active-high.
//  Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, bit counter=0.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start=1 at edge E0 -> latch a into shift reg A and (sub ? ~b : b) into shift reg B;
//         carry = sub; counter = 0; go to RUN.
//   RUN:  one bit per edge: s = A[0]^B[0]^carry; carry <= majority(A[0], B[0], carry);
//         shift A and B right; shift s into the MSB of the internal result register.
//         Record carry-in of bit WIDTH-1 for ovf.
//         After WIDTH RUN edges (E1..E_WIDTH): copy the internal result to sum,
//         copy the final carry to cout, and set ovf. Go to DONE.
//   DONE: done=1 for exactly this one cycle.
//         start=1 here is accepted like in IDLE (back-to-back operation); otherwise go to IDLE.
//  busy=1 exactly in RUN. The bench sees it high for WIDTH cycles after E0.
//  Latency: start sampled at E0 -> done high in cycle after E_WIDTH -> WIDTH+1 cycles.
//  Throughput: one result per WIDTH+1 cycles with start held high.
//  start while busy=1 is ignored. Operands and sub are not re-sampled during RUN.
//  a/b/sub may change freely after acceptance.
//  sum/cout/ovf change only at the completion edge. They are never partial values.
//  Before the first completion after reset they read 0.
//  Arithmetic is modulo 2^WIDTH; no saturation. cout and ovf are both computed
//  in both modes, and the consumer picks the relevant one.
//  Reset asserted mid-operation: immediate return to IDLE with all outputs at their
//  reset values. No done pulse for the aborted operation, and its partial result is discarded.
//  start held high across reset release is accepted on the first clock edge with rst=0.
// TESTING
//  1 WIDTH=8, start with a=0x0F b=0x01 sub=0 -> busy 8 cycles, done pulse at cycle 9;
//    sum=0x10 cout=0 ovf=0.
//  2 WIDTH=8: 0xFF+0x01 -> sum=0x00 cout=1 ovf=0;
//    0x7F+0x01 -> sum=0x80 cout=0 ovf=1;
//    0x80+0x80 -> sum=0x00 cout=1 ovf=1.
//  3 WIDTH=8 sub: 0x05-0x07 -> sum=0xFE cout=0 ovf=0;
//    0x80-0x01 -> sum=0x7F cout=1 ovf=1;
//    0x07-0x07 -> sum=0x00 cout=1.
//  4 Start 0x10+0x20; pulse start with 0xFF+0xFF at cycle 3 of RUN -> ignored.
//    Result is 0x30, exactly one done pulse.
//  5 Start 0x12+0x34; assert rst at cycle 4 of RUN -> busy, done, sum drop to 0 immediately.
//    No done afterwards; a new 0x01+0x01 yields 0x02.
//  6 WIDTH=4: exhaustive a, b, sub (512 cases), start held high back-to-back.
//    Every done checks sum, cout, ovf against a behavioural a+b / a-b model.
//    Period between done pulses must be 5 cycles.

Source files
------------

// File: rtl/serial_adder_n_if.sv
// Request/result bundle for the bit-serial adder: operands and mode in, busy/done and flags out.
interface serial_adder_n_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_n.sv
// Bit-serial add/sub, LSB first, one bit per clock; result WIDTH+1 cycles after start is accepted.
// No backpressure: start is taken only in IDLE/DONE and ignored while busy; results are held, never stalled.
module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  serial_adder_n_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             s_bit;
  logic             c_nxt;
  logic [WIDTH-1:0] res_nxt;

  // The single full-adder cell; subtraction arrives as a + ~b + 1 via the preset carry.
  assign s_bit   = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_nxt   = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign res_nxt = {s_bit, res[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          carry <= c_nxt;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          res   <= res_nxt;
          cnt   <= cnt + CW'(1);
          // On the MSB step, carry is the carry into the MSB and c_nxt the carry out.
          if (cnt == CW'(WIDTH - 1)) begin
            sum_q  <= res_nxt;
            cout_q <= c_nxt;
            ovf_q  <= carry ^ c_nxt;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder_n.sv
// Bench for serial_adder_n: WIDTH=8 vector table and corner sequences, WIDTH=4 exhaustive back-to-back stream.
module tb_serial_adder_n;
  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last4 = -1;
  int   dones8 = 0;
  int   dones4 = 0;

  exp_t q8[$];
  exp_t q4[$];
  vec_t tbl[10];

  serial_adder_n_if #(.WIDTH(8)) if8 ();
  serial_adder_n_if #(.WIDTH(4)) if4 ();

  serial_adder_n #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  serial_adder_n #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model4(input logic [3:0] a, input logic [3:0] b, input logic sub);
    exp_t e;
    logic [4:0] full;
    logic [3:0] r;
    if (sub) full = {1'b0, a} + {1'b0, ~b} + 5'd1;
    else     full = {1'b0, a} + {1'b0, b};
    r      = full[3:0];
    e.sum  = 64'(r);
    e.cout = full[4];
    if (sub) e.ovf = (a[3] != b[3]) && (r[3] != a[3]);
    else     e.ovf = (a[3] == b[3]) && (r[3] != a[3]);
    return e;
  endfunction

  // Scoreboards: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (if8.done) begin
      dones8++;
      if (q8.size() == 0) begin
        check("done8_unexpected", 64'(if8.sum), 64'hDEAD);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("sum8", 64'(if8.sum), e.sum);
        check("cout8", 64'(if8.cout), 64'(e.cout));
        check("ovf8", 64'(if8.ovf), 64'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (if4.done) begin
      dones4++;
      if (last4 >= 0) check("period4", 64'(cyc - last4), 64'd5);
      last4 = cyc;
      if (q4.size() == 0) begin
        check("done4_unexpected", 64'(if4.sum), 64'hDEAD);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("sum4", 64'(if4.sum), e.sum);
        check("cout4", 64'(if4.cout), 64'(e.cout));
        check("ovf4", 64'(if4.ovf), 64'(e.ovf));
      end
    end
  end

  task automatic push8(input logic [7:0] s, input logic c, input logic o);
    exp_t e;
    e.sum = 64'(s);
    e.cout = c;
    e.ovf = o;
    q8.push_back(e);
  endtask

  task automatic wait_done8(input string name, output int cycles, output int nbusy);
    cycles = 0;
    nbusy = 0;
    while (cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) if8.start = 1'b0;
      if (if8.done) break;
      if (if8.busy) nbusy++;
    end
    if (!if8.done) check({name, "_timeout"}, 64'(cycles), 64'd9);
  endtask

  initial begin
    int c;
    int nb;
    int cnt;
    exp_t e;

    tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[4] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[6] = '{8'h07, 8'h07, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[8] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[9] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};

    rst = 1'b1;
    if8.start = 1'b0; if8.sub = 1'b0; if8.a = '0; if8.b = '0;
    if4.start = 1'b0; if4.sub = 1'b0; if4.a = '0; if4.b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(if8.busy), 64'd0);
    check("rst_done", 64'(if8.done), 64'd0);
    check("rst_sum", 64'(if8.sum), 64'd0);
    check("rst_cout", 64'(if8.cout), 64'd0);
    check("rst_ovf", 64'(if8.ovf), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors: latency, busy length and single-cycle done for each.
    for (int i = 0; i < 10; i++) begin
      if8.a = tbl[i].a; if8.b = tbl[i].b; if8.sub = tbl[i].sub; if8.start = 1'b1;
      push8(tbl[i].sum, tbl[i].cout, tbl[i].ovf);
      wait_done8("tbl", c, nb);
      check("tbl_latency", 64'(c), 64'd9);
      check("tbl_busy_cycles", 64'(nb), 64'd8);
      check("tbl_done_busy", 64'(if8.busy), 64'd0);
      @(negedge clk);
      check("tbl_done_pulse", 64'(if8.done), 64'd0);
    end

    // start during RUN must be ignored.
    cnt = dones8;
    if8.a = 8'h10; if8.b = 8'h20; if8.sub = 1'b0; if8.start = 1'b1;
    push8(8'h30, 1'b0, 1'b0);
    @(negedge clk); if8.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if8.a = 8'hFF; if8.b = 8'hFF; if8.start = 1'b1;
    @(negedge clk); if8.start = 1'b0;
    repeat (20) @(negedge clk);
    check("ignored_start_dones", 64'(dones8 - cnt), 64'd1);
    check("ignored_start_q", 64'(q8.size()), 64'd0);

    // Reset mid-run aborts with no done.
    cnt = dones8;
    if8.a = 8'h12; if8.b = 8'h34; if8.sub = 1'b0; if8.start = 1'b1;
    @(negedge clk); if8.start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", 64'(if8.busy), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(if8.busy), 64'd0);
    check("abort_done", 64'(if8.done), 64'd0);
    check("abort_sum", 64'(if8.sum), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_no_done", 64'(dones8 - cnt), 64'd0);

    // start held across reset release is taken on the first edge out of reset.
    rst = 1'b1;
    if8.a = 8'h01; if8.b = 8'h01; if8.sub = 1'b0; if8.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push8(8'h02, 1'b0, 1'b0);
    wait_done8("post_rst", c, nb);
    check("post_rst_latency", 64'(c), 64'd9);
    @(negedge clk);

    // WIDTH=4 exhaustive, start held high back-to-back.
    for (int i = 0; i < 512; i++) begin
      int g;
      g = 0;
      while (if4.busy && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (g >= 50) begin
        check("stream4_timeout", 64'(i), 64'd512);
        break;
      end
      if4.sub = i[8]; if4.a = i[7:4]; if4.b = i[3:0]; if4.start = 1'b1;
      e = model4(i[7:4], i[3:0], i[8]);
      q4.push_back(e);
      @(negedge clk);
    end
    if4.start = 1'b0;

    c = 0;
    while ((q4.size() != 0 || q8.size() != 0) && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("final_q8", 64'(q8.size()), 64'd0);
    check("final_q4", 64'(q4.size()), 64'd0);
    check("stream4_dones", 64'(dones4), 64'd512);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
